fetch_unit: RTL and testbench

// - Instruction fetch stage directly upstream of the core's decode/execute FSM.
// - Issues word-aligned reads to instruction memory over a valid/ready request

---
 rtl/fetch_unit_if.sv | 67 ++++++
 rtl/fetch_unit.sv | 172 +++++++++++++++++
 tb/tb_fetch_unit.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// ---------------------------------------------------------------------------
// fetch_unit_if
//
// Purpose:
//   Bundles every bus the fetch stage talks on:
//     - the instruction-memory request channel;
//     - the instruction-memory response channel;
//     - the decoded-side instruction channel;
//     - the redirect (jump/branch) input.
//
// Handshake semantics (all channels):
//   - A transfer happens on a rising clk edge where both valid and ready are 1.
//   - The imem response channel has no ready: every valid beat is a transfer.
//   - The producer holds or withdraws valid purely from its own state.
//   - Payload is only meaningful while valid is 1.
//
// Modports:
//   master : the fetch unit (drives imem_req_*, inst_valid/inst_data/inst_pc)
//   slave  : the environment (memory, consumer, redirect source)
//
// Signals:
//   imem_req_valid / imem_req_ready / imem_req_addr[31:0]
//   imem_rsp_valid / imem_rsp_data[31:0]
//   inst_valid / inst_ready / inst_data[31:0] / inst_pc[31:0]
//   redirect_valid / redirect_pc[31:0]
// ---------------------------------------------------------------------------
interface fetch_unit_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    modport master (
        output imem_req_valid,
        input  imem_req_ready,
        output imem_req_addr,
        input  imem_rsp_valid,
        input  imem_rsp_data,
        output inst_valid,
        input  inst_ready,
        output inst_data,
        output inst_pc,
        input  redirect_valid,
        input  redirect_pc
    );

    modport slave (
        input  imem_req_valid,
        output imem_req_ready,
        input  imem_req_addr,
        output imem_rsp_valid,
        output imem_rsp_data,
        input  inst_valid,
        output inst_ready,
        input  inst_data,
        input  inst_pc,
        output redirect_valid,
        output redirect_pc
    );
endinterface

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//
// Purpose:
//   Instruction fetch stage in front of the decode/execute FSM.
//   - Issues word-aligned reads to instruction memory.
//   - Accepts the in-order responses.
//   - Buffers {pc, inst} pairs in a small FIFO.
//   - Hands the pairs downstream.
//   - A redirect flushes the FIFO, discards every response still in flight,
//     and restarts fetch at the new pc.
//
// Parameters:
//   RESET_PC   : fetch address after reset
//   FIFO_DEPTH : instruction buffer entries (>=1); also the cap on
//                buffered + outstanding requests
//
// Ports:
//   clk   : clock, all logic on posedge
//   reset : synchronous, active-high reset
//   bus   : fetch_unit_if.master (imem request/response, instruction
//           output, redirect input)
//
// Build option:
//   FETCH_EBREAK_STOP_EN
//     When defined:
//       - Pushing an EBREAK word (32'h0010_0073) sets a halt flag.
//       - The halt flag blocks further requests.
//       - Buffered and in-flight words still drain normally.
//       - redirect or reset clears the halt flag.
//     When undefined:
//       - Fetch runs straight past EBREAK.
// ---------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset,
    fetch_unit_if.master bus
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    localparam logic [CNT_W:0]   DEPTH_EXT = (CNT_W + 1)'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(FIFO_DEPTH - 1);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [31:0]      fetch_pc;     // address of the next request
    logic [31:0]      rsp_pc;       // pc belonging to the next kept response
    logic [CNT_W-1:0] count;        // FIFO occupancy
    logic [CNT_W-1:0] outstanding;  // requests issued, response not yet seen
    logic [CNT_W-1:0] drop_cnt;     // stale responses still to be discarded
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    logic [31:0]      fifo_pc   [FIFO_DEPTH];
    logic [31:0]      fifo_data [FIFO_DEPTH];

    logic             halted;

    // -----------------------------------------------------------------------
    // Combinational control
    // -----------------------------------------------------------------------
    logic [CNT_W:0] credits_used;
    logic           req_valid;
    logic           req_fire;
    logic           rsp_keep;
    logic           rsp_drop;
    logic           push;
    logic           pop;
    logic           head_valid;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    // Buffered plus in-flight words never exceed the FIFO size.
    // A response therefore always finds a free slot.
    assign credits_used = {1'b0, count} + {1'b0, outstanding};

    assign req_valid = !reset && !bus.redirect_valid && !halted
                       && (credits_used < DEPTH_EXT);
    assign req_fire  = req_valid && bus.imem_req_ready;

    assign rsp_keep  = bus.imem_rsp_valid && (drop_cnt == '0);
    assign rsp_drop  = bus.imem_rsp_valid && (drop_cnt != '0);

    // A redirect discards even responses that would otherwise be kept.
    assign push      = rsp_keep && !bus.redirect_valid && !reset;

    assign head_valid = (count != '0) && !reset;
    assign pop        = head_valid && !bus.redirect_valid && bus.inst_ready;

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = fetch_pc;
    assign bus.inst_valid     = head_valid && !bus.redirect_valid;
    assign bus.inst_data      = head_valid ? fifo_data[rd_ptr] : '0;
    assign bus.inst_pc        = head_valid ? fifo_pc[rd_ptr]   : '0;

    // -----------------------------------------------------------------------
    // Counters, pointers and pcs
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            count       <= '0;
            outstanding <= '0;
            drop_cnt    <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else if (bus.redirect_valid) begin
            fetch_pc    <= {bus.redirect_pc[31:2], 2'b00};
            rsp_pc      <= {bus.redirect_pc[31:2], 2'b00};
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            // No request issues this cycle.
            // Every request still in flight after this edge belongs to the
            // old path, so all of them are marked for discard.
            outstanding <= outstanding - CNT_W'(bus.imem_rsp_valid);
            drop_cnt    <= outstanding - CNT_W'(bus.imem_rsp_valid);
        end else begin
            if (req_fire) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
            outstanding <= outstanding + CNT_W'(req_fire)
                           - CNT_W'(bus.imem_rsp_valid);
            if (rsp_drop) begin
                drop_cnt <= drop_cnt - CNT_W'(1);
            end
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
                rsp_pc <= rsp_pc + 32'd4;
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Storage needs no reset: count gates every read of it.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc[wr_ptr]   <= rsp_pc;
            fifo_data[wr_ptr] <= bus.imem_rsp_data;
        end
    end

    // -----------------------------------------------------------------------
    // Optional stop-on-EBREAK
    // -----------------------------------------------------------------------
`ifdef FETCH_EBREAK_STOP_EN
    localparam logic [31:0] EBREAK_WORD = 32'h0010_0073;

    always_ff @(posedge clk) begin
        if (reset || bus.redirect_valid) begin
            halted <= 1'b0;
        end else if (push && (bus.imem_rsp_data == EBREAK_WORD)) begin
            halted <= 1'b1;
        end
    end
`else
    assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic clk = 1'b0;
  logic reset;

  fetch_unit_if bus ();

  fetch_unit #(
    .RESET_PC  (32'h0),
    .FIFO_DEPTH(2)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // -------------------------------------------------------------------------
  // Clock
  // -------------------------------------------------------------------------
  always #5 clk = ~clk;

  // -------------------------------------------------------------------------
  // Vector record: inputs for one cycle plus the outputs expected in it.
  // -------------------------------------------------------------------------
  typedef struct {
    bit          rst;
    bit          ir;      // inst_ready
    bit          rr;      // imem_req_ready
    bit          rdv;     // redirect_valid
    logic [31:0] rpc;     // redirect_pc
    int          lat;     // memory latency applied to a request this cycle
    bit          e_rv;    // expected imem_req_valid
    logic [31:0] e_addr;  // expected imem_req_addr (checked when rst=0)
    bit          e_iv;    // expected inst_valid
    logic [31:0] e_pc;    // expected inst_pc (checked when e_iv=1)
  } vec_t;

  vec_t vecs[$];

  int checks = 0;
  int errors = 0;

  // Memory model: slot k holds a response due k cycles from now.
  bit          mv [0:7];
  logic [31:0] ma [0:7];
  bit          ebreak_en = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (ebreak_en && a == 32'h30) return 32'h0010_0073;
    return a ^ 32'h1357_0000;
  endfunction

  function automatic vec_t v(input bit rst, input bit ir, input bit rr,
                             input bit rdv, input logic [31:0] rpc,
                             input int lat, input bit e_rv,
                             input logic [31:0] e_addr, input bit e_iv,
                             input logic [31:0] e_pc);
    vec_t t;
    t.rst = rst; t.ir = ir; t.rr = rr; t.rdv = rdv; t.rpc = rpc;
    t.lat = lat; t.e_rv = e_rv; t.e_addr = e_addr; t.e_iv = e_iv;
    t.e_pc = e_pc;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  // One clock cycle: drive at negedge, compare #1 later, advance to next negedge.
  task automatic step(input vec_t t, input string tag, input int idx);
    if (t.rst) begin
      for (int k = 0; k < 8; k++) begin
        mv[k] = 1'b0;
        ma[k] = '0;
      end
    end
    reset              = t.rst;
    bus.inst_ready     = t.ir;
    bus.imem_req_ready = t.rr;
    bus.redirect_valid = t.rdv;
    bus.redirect_pc    = t.rpc;
    bus.imem_rsp_valid = mv[0];
    bus.imem_rsp_data  = mv[0] ? mem_word(ma[0]) : 32'h0;
    #1;
    chk($sformatf("%s[%0d].req_valid", tag, idx), 32'(bus.imem_req_valid), 32'(t.e_rv));
    chk($sformatf("%s[%0d].inst_valid", tag, idx), 32'(bus.inst_valid), 32'(t.e_iv));
    if (!t.rst)
      chk($sformatf("%s[%0d].req_addr", tag, idx), bus.imem_req_addr, t.e_addr);
    if (t.e_iv) begin
      chk($sformatf("%s[%0d].inst_pc", tag, idx), bus.inst_pc, t.e_pc);
      chk($sformatf("%s[%0d].inst_data", tag, idx), bus.inst_data, mem_word(t.e_pc));
    end
    if (bus.imem_req_valid === 1'b1 && bus.imem_req_ready === 1'b1) begin
      mv[t.lat] = 1'b1;
      ma[t.lat] = bus.imem_req_addr;
    end
    for (int k = 0; k < 7; k++) begin
      mv[k] = mv[k+1];
      ma[k] = ma[k+1];
    end
    mv[7] = 1'b0;
    ma[7] = '0;
    @(posedge clk);
    @(negedge clk);
  endtask

  // -------------------------------------------------------------------------
  // Test
  // -------------------------------------------------------------------------
  initial begin
    for (int k = 0; k < 8; k++) begin
      mv[k] = 1'b0;
      ma[k] = '0;
    end
    reset              = 1'b1;
    bus.inst_ready     = 1'b0;
    bus.imem_req_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    @(negedge clk);

    // ---- streaming from reset, 1-cycle memory, consumer always ready ----
    vecs.push_back(v(1,1,1,0,0,1, 0,32'h0 ,0,32'h0));
    vecs.push_back(v(1,1,1,0,0,1, 0,32'h0 ,0,32'h0));
    vecs.push_back(v(0,1,1,0,0,1, 1,32'h0 ,0,32'h0));
    vecs.push_back(v(0,1,1,0,0,1, 1,32'h4 ,0,32'h0));
    vecs.push_back(v(0,1,1,0,0,1, 0,32'h8 ,1,32'h0));
    vecs.push_back(v(0,1,1,0,0,1, 1,32'h8 ,1,32'h4));
    vecs.push_back(v(0,1,1,0,0,1, 1,32'hC ,0,32'h0));
    vecs.push_back(v(0,1,1,0,0,1, 0,32'h10,1,32'h8));
    vecs.push_back(v(0,1,1,0,0,1, 1,32'h10,1,32'hC));
    // ---- consumer stalled: two requests fill the buffer, then release ----
    vecs.push_back(v(1,0,1,0,0,1, 0,32'h0 ,0,32'h0));
    vecs.push_back(v(0,0,1,0,0,1, 1,32'h0 ,0,32'h0));
    vecs.push_back(v(0,0,1,0,0,1, 1,32'h4 ,0,32'h0));
    vecs.push_back(v(0,0,1,0,0,1, 0,32'h8 ,1,32'h0));
    vecs.push_back(v(0,0,1,0,0,1, 0,32'h8 ,1,32'h0));
    vecs.push_back(v(0,0,1,0,0,1, 0,32'h8 ,1,32'h0));
    vecs.push_back(v(0,1,1,0,0,1, 0,32'h8 ,1,32'h0));
    vecs.push_back(v(0,1,1,0,0,1, 1,32'h8 ,1,32'h4));
    vecs.push_back(v(0,1,1,0,0,1, 1,32'hC ,0,32'h0));
    vecs.push_back(v(0,1,1,0,0,1, 0,32'h10,1,32'h8));
    // ---- imem_req_ready toggling ----
    vecs.push_back(v(1,1,1,0,0,1, 0,32'h0 ,0,32'h0));
    vecs.push_back(v(0,1,1,0,0,1, 1,32'h0 ,0,32'h0));
    vecs.push_back(v(0,1,0,0,0,1, 1,32'h4 ,0,32'h0));
    vecs.push_back(v(0,1,1,0,0,1, 1,32'h4 ,1,32'h0));
    vecs.push_back(v(0,1,0,0,0,1, 1,32'h8 ,0,32'h0));
    vecs.push_back(v(0,1,1,0,0,1, 1,32'h8 ,1,32'h4));
    vecs.push_back(v(0,1,0,0,0,1, 1,32'hC ,0,32'h0));
    vecs.push_back(v(0,1,1,0,0,1, 1,32'hC ,1,32'h8));
    // ---- 3-cycle memory, redirect to 0x103 with two outstanding ----
    vecs.push_back(v(1,1,1,0,0,3, 0,32'h0  ,0,32'h0));
    vecs.push_back(v(0,1,1,0,0,3, 1,32'h0  ,0,32'h0));
    vecs.push_back(v(0,1,1,0,0,3, 1,32'h4  ,0,32'h0));
    vecs.push_back(v(0,1,1,1,32'h103,3, 0,32'h8,0,32'h0));
    vecs.push_back(v(0,1,1,0,0,3, 0,32'h100,0,32'h0));
    vecs.push_back(v(0,1,1,0,0,3, 1,32'h100,0,32'h0));
    vecs.push_back(v(0,1,1,0,0,3, 1,32'h104,0,32'h0));
    vecs.push_back(v(0,1,1,0,0,3, 0,32'h108,0,32'h0));
    vecs.push_back(v(0,1,1,0,0,3, 0,32'h108,0,32'h0));
    vecs.push_back(v(0,1,1,0,0,3, 0,32'h108,1,32'h100));
    vecs.push_back(v(0,0,1,0,0,3, 1,32'h108,1,32'h104));
    // redirect while the buffer holds a word and one request is in flight
    vecs.push_back(v(0,1,1,1,32'h200,3, 0,32'h10C,0,32'h0));
    vecs.push_back(v(0,1,1,0,0,3, 1,32'h200,0,32'h0));
    vecs.push_back(v(0,1,1,0,0,3, 0,32'h204,0,32'h0));
    vecs.push_back(v(0,1,1,0,0,3, 1,32'h204,0,32'h0));
    vecs.push_back(v(0,1,1,0,0,3, 0,32'h208,0,32'h0));
    vecs.push_back(v(0,1,1,0,0,3, 0,32'h208,1,32'h200));
    vecs.push_back(v(0,1,1,0,0,3, 1,32'h208,0,32'h0));
    // ---- reset with the buffer full ----
    vecs.push_back(v(1,0,1,0,0,1, 0,32'h0 ,0,32'h0));
    vecs.push_back(v(0,0,1,0,0,1, 1,32'h0 ,0,32'h0));
    vecs.push_back(v(0,0,1,0,0,1, 1,32'h4 ,0,32'h0));
    vecs.push_back(v(0,0,1,0,0,1, 0,32'h8 ,1,32'h0));
    vecs.push_back(v(0,0,1,0,0,1, 0,32'h8 ,1,32'h0));
    vecs.push_back(v(1,0,1,0,0,1, 0,32'h0 ,0,32'h0));
    vecs.push_back(v(0,0,1,0,0,1, 1,32'h0 ,0,32'h0));

    for (int i = 0; i < vecs.size(); i++) step(vecs[i], "tbl", i);

    // ---- redirect in the same cycle as a response that would be kept,
    //      then pc wrap at the top of the address space ----
    step(v(1,1,1,0,0,1,            0,32'h0       ,0,32'h0       ), "redir_rsp", 0);
    step(v(0,1,1,0,0,1,            1,32'h0       ,0,32'h0       ), "redir_rsp", 1);
    step(v(0,1,1,1,32'h40,1,       0,32'h4       ,0,32'h0       ), "redir_rsp", 2);
    step(v(0,1,1,0,0,1,            1,32'h40      ,0,32'h0       ), "redir_rsp", 3);
    step(v(0,1,1,0,0,1,            1,32'h44      ,0,32'h0       ), "redir_rsp", 4);
    step(v(0,1,1,0,0,1,            0,32'h48      ,1,32'h40      ), "redir_rsp", 5);
    step(v(0,1,1,1,32'hFFFF_FFFF,1,0,32'h48      ,0,32'h0       ), "wrap", 0);
    step(v(0,1,1,0,0,1,            1,32'hFFFF_FFFC,0,32'h0      ), "wrap", 1);
    step(v(0,1,1,0,0,1,            1,32'h0       ,0,32'h0       ), "wrap", 2);
    step(v(0,1,1,0,0,1,            0,32'h4       ,1,32'hFFFF_FFFC), "wrap", 3);
    step(v(0,1,1,0,0,1,            1,32'h4       ,1,32'h0       ), "wrap", 4);

`ifdef FETCH_EBREAK_STOP_EN
    // ---- EBREAK at 0x30 halts fetch; redirect to 0 restarts it ----
    ebreak_en = 1'b1;
    step(v(1,1,1,0,0,1,       0,32'h0 ,0,32'h0 ), "ebreak", 0);
    step(v(0,1,1,1,32'h30,1,  0,32'h0 ,0,32'h0 ), "ebreak", 1);
    step(v(0,1,1,0,0,1,       1,32'h30,0,32'h0 ), "ebreak", 2);
    step(v(0,1,1,0,0,1,       1,32'h34,0,32'h0 ), "ebreak", 3);
    step(v(0,1,1,0,0,1,       0,32'h38,1,32'h30), "ebreak", 4);
    step(v(0,1,1,0,0,1,       0,32'h38,1,32'h34), "ebreak", 5);
    step(v(0,1,1,0,0,1,       0,32'h38,0,32'h0 ), "ebreak", 6);
    step(v(0,1,1,1,32'h0,1,   0,32'h38,0,32'h0 ), "ebreak", 7);
    step(v(0,1,1,0,0,1,       1,32'h0 ,0,32'h0 ), "ebreak", 8);
    ebreak_en = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
